serial_sign_magnitude_decoder: RTL

- Bit-serial converter from two's-complement to sign-magnitude; the inverse of the team's combinational complement-of-2 negator.
- Accepts one WIDTH-bit signed word per transaction over a valid/ready handshake and processes it LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule.
- Presents sign and magnitude on a second valid/ready port.
- Sits between ALU result registers and display/BCD logic that expects sign-magnitude.

---
 rtl/serial_sign_magnitude_decoder_pkg.sv | 23 ++
 rtl/serial_sign_magnitude_decoder_if.sv | 36 +++
 rtl/serial_sign_magnitude_decoder_complement_cell.sv | 14 +
 rtl/serial_sign_magnitude_decoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/serial_sign_magnitude_decoder_pkg.sv
// Shared types and constants for the serial sign-magnitude decoder.
// The optional SMD_MINVAL_FLAG_EN build flag is handled in the interface and top.
package smd_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Ceiling log2, used to size the bit counter
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sign_magnitude_decoder_if.sv
// Input word and output result handshakes of the serial sign-magnitude decoder.
// SMD_MINVAL_FLAG_EN adds the out_minval flag to the result side.
interface serial_sign_magnitude_decoder_if
  import smd_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
`ifdef SMD_MINVAL_FLAG_EN
  logic             out_minval;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag
`ifdef SMD_MINVAL_FLAG_EN
    , input out_minval
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag
`ifdef SMD_MINVAL_FLAG_EN
    , output out_minval
`endif
  );

endinterface

// File: rtl/serial_sign_magnitude_decoder_complement_cell.sv
// Per-bit two's-complement negation rule: copy bits up to and including the
// first one, invert every bit after it (only when the word is negative).
module serial_complement_cell (
  input  logic b,
  input  logic sign,
  input  logic seen_one,
  output logic r,
  output logic next_seen_one
);

  assign r             = (sign & seen_one) ? ~b : b;
  assign next_seen_one = seen_one | (sign & b);

endmodule

// File: rtl/serial_sign_magnitude_decoder.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit per clock.
// Defining SMD_MINVAL_FLAG_EN adds out_minval, flagging the most negative input.
module serial_sign_magnitude_decoder
  import smd_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  serial_sign_magnitude_decoder_if.slave bus
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINVAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_n;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             seen_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             r_c;
  logic             seen_n_c;
  logic             accept_c;
  logic             last_c;

  assign accept_c = (state == IDLE) && bus.in_valid;
  assign last_c   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  serial_complement_cell u_cell (
    .b             (shreg[0]),
    .sign          (sign_q),
    .seen_one      (seen_q),
    .r             (r_c),
    .next_seen_one (seen_n_c)
  );

  // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
  assign mag_n = {r_c, mag_q[WIDTH-1:1]};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_n = SHIFT;
      SHIFT:   if (last_c)        state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  // State register and handshake outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      mag_q  <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      seen_q <= 1'b0;
    end else if (accept_c) begin
      shreg  <= bus.in_data;
      mag_q  <= '0;
      cnt    <= '0;
      sign_q <= bus.in_data[WIDTH-1];
      seen_q <= 1'b0;
    end else if (state == SHIFT) begin
      shreg  <= shreg >> 1;
      mag_q  <= mag_n;
      cnt    <= cnt + CW'(1);
      seen_q <= seen_n_c;
    end
  end

`ifdef SMD_MINVAL_FLAG_EN
  logic minval_q;

  // Evaluated on the final shift edge so it is valid together with out_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      minval_q <= 1'b0;
    end else if (accept_c) begin
      minval_q <= 1'b0;
    end else if (last_c) begin
      minval_q <= sign_q && (mag_n == MINVAL);
    end
  end

  assign bus.out_minval = minval_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = sign_q;
  assign bus.out_mag   = mag_q;

endmodule
